ripple_carry: RTL and testbench
===============================

RIPPLE_CARRY -- requirements
Module: ripple_carry

Interface
REQ-001 Parameter: n, default 8, operand/sum width in bits; legal range n >= 1.
REQ-002 Port: clk  input  1  rising-edge clock for all registers.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: A  input  n  unsigned/two's-complement operand A.
REQ-005 Port: B  input  n  operand B.
REQ-006 Port: c  input  1  carry-in to bit 0.
REQ-007 Port: in_valid  input  1  operands valid this cycle; capture enable.
REQ-008 Port: sum  output  n  registered sum bits.
REQ-009 Port: c_out  output  1  registered carry out of bit n-1.
REQ-010 Port: ovf  output  1  registered signed-overflow flag.
REQ-011 Port: out_valid  output  1  registered qualifier for sum/c_out/ovf.

Function
REQ-012 Datapath SHALL be n chained full-adder stages; carry into stage i is carry out of stage i-1; stage 0 carry-in is c; no lookahead or prefix logic.
REQ-013 Each stage SHALL compute s_i = A_i ^ B_i ^ k_i, k_(i+1) = A_i&B_i | A_i&k_i | B_i&k_i.
REQ-014 {c_out, sum} SHALL equal A + B + c modulo 2^(n+1), exact for all inputs.
REQ-015 Latency SHALL be 1 cycle: on rising clk with in_valid=1, sum, c_out, ovf load the adder result; out_valid loads 1.
REQ-016 On rising clk with in_valid=0, sum, c_out, ovf SHALL hold previous values; out_valid loads 0.
REQ-017 Back-to-back in_valid=1 cycles SHALL produce one result per cycle, throughput 1/cycle, no stalls.
REQ-018 ovf SHALL be k_n ^ k_(n-1) (carry into MSB XOR carry out of MSB); for n=1 use c ^ c_out.
REQ-019 Inputs are sampled only at rising clk; combinational glitches on A, B, c between edges SHALL not affect outputs.

Reset
REQ-020 While rst_n=0, sum, c_out, ovf, out_valid SHALL be 0, taking effect immediately without a clock edge.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight result; no output shows it after release.
REQ-022 First capture SHALL occur on the first rising clk with rst_n=1 and in_valid=1.

Configuration
REQ-023 Macro RIPPLE_CARRY_OVF_EN: when defined, ovf SHALL be computed per REQ-018; when undefined, ovf port SHALL remain present and be driven constant 0, with no overflow logic synthesized.
REQ-024 All other behaviour SHALL be identical with or without RIPPLE_CARRY_OVF_EN.

Verification
REQ-025 n=8, A=0xCA, B=0xAE, c=0, in_valid=1 -> next edge: sum=0x78, c_out=1, ovf=1 (macro on), out_valid=1.
REQ-026 A=0xFF, B=0x00, c=1, in_valid=1 -> sum=0x00, c_out=1, ovf=0 (full carry ripple through all 8 stages).
REQ-027 A=0x7F, B=0x01, c=0, in_valid=1 -> sum=0x80, c_out=0, ovf=1 (macro on) / ovf=0 (macro off).
REQ-028 After REQ-025 result, in_valid=0 with A=B=0x55 for 3 cycles -> sum=0x78, c_out=1 held, out_valid=0.
REQ-029 Drive rst_n=0 between clock edges while outputs nonzero -> sum, c_out, ovf, out_valid read 0 before next edge; stay 0 until a valid capture after release.
REQ-030 Random A, B, c with in_valid=1 every cycle, 10000 cycles -> each {c_out,sum} equals A+B+c from previous cycle.

Source files
------------

// File: rtl/ripple_carry.sv
// ripple_carry: n-bit ripple-carry adder with registered sum, carry-out and signed-overflow flag.
// Latency: 1 cycle from an in_valid capture edge to out_valid; throughput is one result per cycle.
// Backpressure: none; every in_valid cycle is accepted, and outputs hold while in_valid is low.
// Optional feature: define RIPPLE_CARRY_OVF_EN to build the overflow flag, otherwise ovf is tied to 0.
module ripple_carry #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic         c,
   input  logic         in_valid,
   output logic [n-1:0] sum,
   output logic         c_out,
   output logic         ovf,
   output logic         out_valid
);

   // k[i] is the carry into stage i; k[n] is the carry out of the MSB.
   logic [n:0]   k;
   logic [n-1:0] s;

   assign k[0] = c;

   // Chain of full adders; each stage waits on the carry from the stage below.
   for (genvar i = 0; i < n; i++) begin : g_fa
      assign s[i]   = A[i] ^ B[i] ^ k[i];
      assign k[i+1] = (A[i] & B[i]) | (A[i] & k[i]) | (B[i] & k[i]);
   end

   // Result registers: load on in_valid, hold otherwise; reset clears them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= '0;
         c_out <= 1'b0;
      end else if (in_valid) begin
         sum   <= s;
         c_out <= k[n];
      end
   end

   // Output qualifier tracks the previous cycle's in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

`ifdef RIPPLE_CARRY_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it (for n=1, k[0] is c).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (in_valid) begin
         ovf_q <= k[n] ^ k[n-1];
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_carry.sv
// Testbench for ripple_carry (n=8): directed vectors, hold, async reset and a random stream.
// Expected results come from an arithmetic model pushed to a scoreboard queue at drive time.
// Honours RIPPLE_CARRY_OVF_EN when predicting ovf.
module tb_ripple_carry;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         cin = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic         out_valid;

   typedef struct packed {
      logic [N-1:0] s;
      logic         co;
      logic         ov;
   } res_t;

   res_t sb[$];
   res_t last = '0;
   int   checks = 0;
   int   errors = 0;

   ripple_carry #(.n(N)) dut (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .c(cin), .in_valid(in_valid),
      .sum(sum), .c_out(c_out), .ovf(ovf), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference: plain integer addition; overflow from operand/result sign rule.
   function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
      logic [N:0] t;
      res_t r;
      t = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
      r.s  = t[N-1:0];
      r.co = t[N];
`ifdef RIPPLE_CARRY_OVF_EN
      r.ov = (x[N-1] == y[N-1]) && (r.s[N-1] != x[N-1]);
`else
      r.ov = 1'b0;
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; outputs are checked 1 ns after the capture edge.
   task automatic step(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic ci, input logic v);
      res_t e;
      @(negedge clk);
      a = x; b = y; cin = ci; in_valid = v;
      if (v) sb.push_back(model(x, y, ci));
      @(posedge clk);
      #1;
      if (v) begin
         chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.s));
            chk({tag, "_cout"}, 32'(c_out), 32'(e.co));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
            chk({tag, "_vld"}, 32'(out_valid), 32'd1);
            last = e;
         end
      end else begin
         chk({tag, "_hold_sum"}, 32'(sum), 32'(last.s));
         chk({tag, "_hold_cout"}, 32'(c_out), 32'(last.co));
         chk({tag, "_hold_ovf"}, 32'(ovf), 32'(last.ov));
         chk({tag, "_vld"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      logic exp_ov27;
      // Reset state
      #2;
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(c_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // First capture after release, with fixed constants from the datasheet vectors
      step("v25", 8'hCA, 8'hAE, 1'b0, 1'b1);
      chk("v25_sum_const", 32'(sum), 32'h78);
      chk("v25_cout_const", 32'(c_out), 32'd1);
`ifdef RIPPLE_CARRY_OVF_EN
      chk("v25_ovf_const", 32'(ovf), 32'd1);
`else
      chk("v25_ovf_const", 32'(ovf), 32'd0);
`endif

      // Held for three idle cycles while inputs change underneath
      for (int i = 0; i < 3; i++) begin
         step("hold", 8'h55, 8'h55, 1'b0, 1'b0);
         chk("hold_sum_const", 32'(sum), 32'h78);
      end

      // Carry ripples through every stage
      step("v26", 8'hFF, 8'h00, 1'b1, 1'b1);
      chk("v26_sum_const", 32'(sum), 32'h00);
      chk("v26_cout_const", 32'(c_out), 32'd1);
      chk("v26_ovf_const", 32'(ovf), 32'd0);

      // Positive overflow into the sign bit
      step("v27", 8'h7F, 8'h01, 1'b0, 1'b1);
      chk("v27_sum_const", 32'(sum), 32'h80);
      chk("v27_cout_const", 32'(c_out), 32'd0);
`ifdef RIPPLE_CARRY_OVF_EN
      exp_ov27 = 1'b1;
`else
      exp_ov27 = 1'b0;
`endif
      chk("v27_ovf_const", 32'(ovf), 32'(exp_ov27));

      // Negative overflow and extremes
      step("negovf", 8'h80, 8'h80, 1'b0, 1'b1);
      step("maxmax", 8'hFF, 8'hFF, 1'b1, 1'b1);
      step("zero", 8'h00, 8'h00, 1'b0, 1'b1);

      // Async reset mid-cycle while outputs are nonzero, with a capture pending
      step("pre_rst", 8'hCA, 8'hAE, 1'b0, 1'b1);
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sum", 32'(sum), 32'd0);
      chk("arst_cout", 32'(c_out), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      chk("arst_vld", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("inrst_sum", 32'(sum), 32'd0);
      chk("inrst_vld", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      last = '0;
      step("post_rst_idle", 8'hAA, 8'h11, 1'b1, 1'b0);
      step("post_rst_idle2", 8'hAA, 8'h11, 1'b1, 1'b0);
      step("post_rst_cap", 8'h12, 8'h34, 1'b1, 1'b1);

      // Random back-to-back stream, one result per cycle
      for (int i = 0; i < 10000; i++) begin
         step("rnd", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end

      // Random stream with gaps
      for (int i = 0; i < 200; i++) begin
         step("rndgap", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
